ctrl_pipe: RTL and testbench

Pipelined control unit for the 16-bit core: decodes the 4-bit opcode in ID and carries the control word through EX, MEM and WB pipeline registers. It adds what a purely combinational decoder lacks:
- valid/ready issue handshake;
- bubble insertion and flush;
- parametrised multi-cycle memory wait with pipeline freeze;
- halt-drain state machine.

---
 rtl/ctrl_pipe.sv | 196 +++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes the ID opcode and carries control through EX/MEM/WB,
// with issue handshake, bubbles/flush, multi-cycle memory freeze and halt drain. Define CTRL_PERF_EN for perf counters.
module ctrl_pipe #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [3:0]  id_opcode,
  output logic        id_ready,
  input  logic        hz_stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [2:0]  ex_aluop,
  output logic        ex_alusrc,
  output logic        ex_regdst,
  output logic        ex_branch,
  output logic        ex_brsrc,
  output logic        ex_pcs,
  output logic        mem_valid,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_busy,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic        wb_memtoreg,
  output logic        halted
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_stall
`endif
);

  typedef struct packed {
    logic       halt;
    logic       regwrite;
    logic       memtoreg;
    logic       read;
    logic       write;
    logic       pcs;
    logic       brsrc;
    logic       branch;
    logic       regdst;
    logic       alusrc;
    logic [2:0] aluop;
  } ex_ctrl_t;

  typedef struct packed {
    logic halt;
    logic regwrite;
    logic memtoreg;
    logic read;
    logic write;
  } mem_ctrl_t;

  typedef struct packed {
    logic halt;
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  function automatic ex_ctrl_t decode(input logic [3:0] o);
    ex_ctrl_t c;
    c.aluop    = o[3] ? 3'b000 : o[2:0];
    c.alusrc   = o[3] | (o[2] & ~(o[1] & o[0]));
    c.regwrite = ~o[3] | (o == 4'b1000) | (o == 4'b1010) | (o == 4'b1011) | (o == 4'b1110);
    c.regdst   = ~o[3] | (o == 4'b1110);
    c.read     = (o == 4'b1000);
    c.memtoreg = (o == 4'b1000);
    c.write    = (o == 4'b1001);
    c.branch   = (o[3:1] == 3'b110);
    c.brsrc    = (o[3:1] == 3'b110) & o[0];
    c.pcs      = (o == 4'b1110);
    c.halt     = (o == 4'b1111);
    return c;
  endfunction

  state_t     state_q, state_d;
  logic       ex_v_q, ex_v_d, mem_v_q, mem_v_d, wb_v_q, wb_v_d;
  ex_ctrl_t   ex_c_q, ex_c_d, id_c;
  mem_ctrl_t  mem_c_q, mem_c_d;
  wb_ctrl_t   wb_c_q, wb_c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       mem_wait, accept;

  assign id_c     = decode(id_opcode);
  // The load/store in MEM freezes EX and MEM until it has spent MEM_LAT cycles there.
  assign mem_wait = mem_v_q && (mem_c_q.read || mem_c_q.write) && (int'(cnt_q) < MEM_LAT - 1);
  assign accept   = id_valid & id_ready & ~flush;
  assign cnt_d    = mem_wait ? cnt_q + CNT_W'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && id_c.halt) state_d = DRAIN;
      DRAIN:   if (wb_v_q && wb_c_q.halt) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    id_ready = 1'b0;
    halted   = 1'b0;
    case (state_q)
      RUN:     id_ready = ~mem_wait & (flush | ~hz_stall);
      HALTED:  halted = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ex_v_d  = ex_v_q;
    ex_c_d  = ex_c_q;
    mem_v_d = mem_v_q;
    mem_c_d = mem_c_q;
    wb_v_d  = 1'b0;
    wb_c_d  = '0;
    if (state_q == HALTED) begin
      ex_v_d  = 1'b0;
      ex_c_d  = '0;
      mem_v_d = 1'b0;
      mem_c_d = '0;
    end else if (!mem_wait) begin
      ex_v_d  = accept;
      ex_c_d  = accept ? id_c : '0;
      mem_v_d = ex_v_q;
      mem_c_d = '{halt: ex_c_q.halt, regwrite: ex_c_q.regwrite, memtoreg: ex_c_q.memtoreg,
                  read: ex_c_q.read, write: ex_c_q.write};
      wb_v_d  = mem_v_q;
      wb_c_d  = '{halt: mem_c_q.halt, regwrite: mem_c_q.regwrite, memtoreg: mem_c_q.memtoreg};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q  <= 1'b0;
      ex_c_q  <= '0;
      mem_v_q <= 1'b0;
      mem_c_q <= '0;
      wb_v_q  <= 1'b0;
      wb_c_q  <= '0;
      cnt_q   <= '0;
    end else begin
      ex_v_q  <= ex_v_d;
      ex_c_q  <= ex_c_d;
      mem_v_q <= mem_v_d;
      mem_c_q <= mem_c_d;
      wb_v_q  <= wb_v_d;
      wb_c_q  <= wb_c_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid    = ex_v_q;
  assign ex_aluop    = ex_c_q.aluop;
  assign ex_alusrc   = ex_c_q.alusrc;
  assign ex_regdst   = ex_c_q.regdst;
  assign ex_branch   = ex_c_q.branch;
  assign ex_brsrc    = ex_c_q.brsrc;
  assign ex_pcs      = ex_c_q.pcs;
  assign mem_valid   = mem_v_q;
  assign mem_read    = mem_c_q.read;
  assign mem_write   = mem_c_q.write;
  assign mem_busy    = mem_wait;
  assign wb_valid    = wb_v_q;
  assign wb_regwrite = wb_v_q & wb_c_q.regwrite;
  assign wb_memtoreg = wb_v_q & wb_c_q.memtoreg;

`ifdef CTRL_PERF_EN
  logic [31:0] retired_q, stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_q + 32'(wb_v_q);
      stall_q   <= stall_q + 32'(id_valid & ~id_ready & (state_q == RUN));
    end
  end

  assign perf_retired = retired_q;
  assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: three instances (MEM_LAT 1, 4, 2), decode table, directed corner
// sequences and randomized traffic against a transaction-queue reference model.
module tb_ctrl_pipe;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [N], id_valid [N], hz_stall [N], flush [N], id_ready [N];
  logic [3:0] id_opcode [N];
  logic       ex_valid [N], ex_alusrc [N], ex_regdst [N], ex_branch [N], ex_brsrc [N], ex_pcs [N];
  logic [2:0] ex_aluop [N];
  logic       mem_valid [N], mem_read [N], mem_write [N], mem_busy [N];
  logic       wb_valid [N], wb_regwrite [N], wb_memtoreg [N], halted [N];
`ifdef CTRL_PERF_EN
  logic [31:0] perf_retired [N], perf_stall [N];
`endif

  for (genvar g = 0; g < N; g++) begin : g_dut
    ctrl_pipe #(.MEM_LAT(g == 0 ? 1 : (g == 1 ? 4 : 2)), .CNT_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n[g]), .id_valid(id_valid[g]), .id_opcode(id_opcode[g]),
      .id_ready(id_ready[g]), .hz_stall(hz_stall[g]), .flush(flush[g]),
      .ex_valid(ex_valid[g]), .ex_aluop(ex_aluop[g]), .ex_alusrc(ex_alusrc[g]),
      .ex_regdst(ex_regdst[g]), .ex_branch(ex_branch[g]), .ex_brsrc(ex_brsrc[g]),
      .ex_pcs(ex_pcs[g]), .mem_valid(mem_valid[g]), .mem_read(mem_read[g]),
      .mem_write(mem_write[g]), .mem_busy(mem_busy[g]), .wb_valid(wb_valid[g]),
      .wb_regwrite(wb_regwrite[g]), .wb_memtoreg(wb_memtoreg[g]), .halted(halted[g])
`ifdef CTRL_PERF_EN
      , .perf_retired(perf_retired[g]), .perf_stall(perf_stall[g])
`endif
    );
  end

  // Decoded control: aluop, alusrc, regdst, branch, brsrc, pcs, read, write, regwrite, memtoreg
  typedef struct packed {
    logic [2:0] aluop;
    logic alusrc, regdst, branch, brsrc, pcs, rd, wr, rw, m2r;
  } dec_t;
  typedef struct {
    logic [3:0] op;
    dec_t       d;
  } vec_t;
  typedef struct packed {
    logic id_ready, ex_valid;
    logic [2:0] aluop;
    logic alusrc, regdst, branch, brsrc, pcs;
    logic mem_valid, mem_read, mem_write, mem_busy;
    logic wb_valid, wb_regwrite, wb_memtoreg, halted;
  } out_t;
  typedef struct {
    logic [3:0] op;
    int stage;
    int waited;
  } flight_t;

  vec_t tab [16];
  int   lat_of [N];
  int   checks = 0;
  int   errors = 0;

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic out_t obs(input int k);
    out_t o;
    o.id_ready = id_ready[k];       o.ex_valid = ex_valid[k];
    o.aluop = ex_aluop[k];          o.alusrc = ex_alusrc[k];
    o.regdst = ex_regdst[k];        o.branch = ex_branch[k];
    o.brsrc = ex_brsrc[k];          o.pcs = ex_pcs[k];
    o.mem_valid = mem_valid[k];     o.mem_read = mem_read[k];
    o.mem_write = mem_write[k];     o.mem_busy = mem_busy[k];
    o.wb_valid = wb_valid[k];       o.wb_regwrite = wb_regwrite[k];
    o.wb_memtoreg = wb_memtoreg[k]; o.halted = halted[k];
    return o;
  endfunction

  // Reference model: in-flight instructions with their stage (1=EX,2=MEM,3=WB) and MEM time spent.
  flight_t fq [$];
  int m_lat;
  bit m_drain, m_halted;

  function automatic void m_reset();
    fq.delete();
    m_drain = 0;
    m_halted = 0;
  endfunction

  function automatic bit m_freeze();
    foreach (fq[i])
      if (fq[i].stage == 2 && (fq[i].op == 4'h8 || fq[i].op == 4'h9) && fq[i].waited < m_lat - 1)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready(input bit hz, input bit fl);
    if (m_drain || m_halted || m_freeze()) return 1'b0;
    if (fl) return 1'b1;
    return !hz;
  endfunction

  function automatic out_t m_expect(input bit hz, input bit fl);
    out_t e;
    dec_t d;
    e = '0;
    e.id_ready = m_ready(hz, fl);
    e.halted = m_halted;
    e.mem_busy = m_freeze();
    foreach (fq[i]) begin
      d = tab[fq[i].op].d;
      if (fq[i].stage == 1) begin
        e.ex_valid = 1'b1; e.aluop = d.aluop; e.alusrc = d.alusrc; e.regdst = d.regdst;
        e.branch = d.branch; e.brsrc = d.brsrc; e.pcs = d.pcs;
      end else if (fq[i].stage == 2) begin
        e.mem_valid = 1'b1; e.mem_read = d.rd; e.mem_write = d.wr;
      end else begin
        e.wb_valid = 1'b1; e.wb_regwrite = d.rw; e.wb_memtoreg = d.m2r;
      end
    end
    return e;
  endfunction

  function automatic void m_advance(input bit v, input logic [3:0] op, input bit hz, input bit fl);
    bit fr, rdy;
    flight_t f;
    if (m_halted) return;
    fr  = m_freeze();
    rdy = m_ready(hz, fl);
    for (int i = fq.size() - 1; i >= 0; i--)
      if (fq[i].stage == 3) begin
        if (fq[i].op == 4'hF) begin m_halted = 1; m_drain = 0; end
        fq.delete(i);
      end
    if (fr) begin
      foreach (fq[i]) if (fq[i].stage == 2) fq[i].waited++;
    end else begin
      foreach (fq[i]) fq[i].stage++;
      if (v && rdy && !fl) begin
        f.op = op; f.stage = 1; f.waited = 0;
        fq.push_back(f);
        if (op == 4'hF) m_drain = 1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_random(input int k, input int ncyc);
    bit v, hz, fl, do_rst;
    logic [3:0] op;
    m_lat = lat_of[k];
    id_valid[k] = 0; hz_stall[k] = 0; flush[k] = 0; rst_n[k] = 0;
    tick();
    rst_n[k] = 1;
    m_reset();
    for (int c = 0; c < ncyc; c++) begin
      do_rst = m_halted || ($urandom_range(0, 149) == 0);
      v  = ($urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 29) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      hz = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 7) == 0);
      id_valid[k] = v; id_opcode[k] = op; hz_stall[k] = hz; flush[k] = fl;
      if (do_rst) begin
        rst_n[k] = 0;
        m_reset();
      end
      @(negedge clk);
      chkv($sformatf("rand_dut%0d_cyc%0d", k, c), 32'(obs(k)), 32'(m_expect(hz, fl)));
      rst_n[k] = 1;
      @(posedge clk);
      m_advance(v, op, hz, fl);
      #1;
    end
    id_valid[k] = 0; hz_stall[k] = 0; flush[k] = 0;
  endtask

  initial begin
    logic [11:0] dv [16];
    logic [3:0]  hexp [5];
    out_t rst_exp;
    int idx, issued;

    dv = '{12'b000_0_1_0_0_0_0_0_1_0, 12'b001_0_1_0_0_0_0_0_1_0, 12'b010_0_1_0_0_0_0_0_1_0,
           12'b011_0_1_0_0_0_0_0_1_0, 12'b100_1_1_0_0_0_0_0_1_0, 12'b101_1_1_0_0_0_0_0_1_0,
           12'b110_1_1_0_0_0_0_0_1_0, 12'b111_0_1_0_0_0_0_0_1_0, 12'b000_1_0_0_0_0_1_0_1_1,
           12'b000_1_0_0_0_0_0_1_0_0, 12'b000_1_0_0_0_0_0_0_1_0, 12'b000_1_0_0_0_0_0_0_1_0,
           12'b000_1_0_1_0_0_0_0_0_0, 12'b000_1_0_1_1_0_0_0_0_0, 12'b000_1_1_0_0_1_0_0_1_0,
           12'b000_1_0_0_0_0_0_0_0_0};
    for (int i = 0; i < 16; i++) begin
      tab[i].op = 4'(i);
      tab[i].d  = dv[i];
    end
    lat_of = '{1, 4, 2};

    for (int k = 0; k < N; k++) begin
      rst_n[k] = 0; id_valid[k] = 0; id_opcode[k] = 0; hz_stall[k] = 0; flush[k] = 0;
    end
    repeat (2) tick();
    rst_exp = '0;
    rst_exp.id_ready = 1'b1;
    for (int k = 0; k < N; k++) chkv($sformatf("reset_dut%0d", k), 32'(obs(k)), 32'(rst_exp));
    for (int k = 0; k < N; k++) rst_n[k] = 1;
    tick();

    // Opcodes 0..14 back-to-back through MEM_LAT=1
    for (int i = 0; i < 17; i++) begin
      idx = (i < 15) ? i : 0;
      id_valid[0] = (i < 15);
      id_opcode[0] = tab[idx].op;
      tick();
      chkv($sformatf("dec_ex_%0d", i),
           32'({ex_valid[0], ex_aluop[0], ex_alusrc[0], ex_regdst[0], ex_branch[0], ex_brsrc[0], ex_pcs[0]}),
           (i < 15) ? 32'({1'b1, tab[idx].d.aluop, tab[idx].d.alusrc, tab[idx].d.regdst,
                           tab[idx].d.branch, tab[idx].d.brsrc, tab[idx].d.pcs}) : 32'd0);
      if (i >= 1 && i <= 15)
        chkv($sformatf("dec_mem_%0d", i - 1), 32'({mem_valid[0], mem_read[0], mem_write[0]}),
             32'({1'b1, tab[i-1].d.rd, tab[i-1].d.wr}));
      if (i >= 2)
        chkv($sformatf("dec_wb_%0d", i - 2), 32'({wb_valid[0], wb_regwrite[0], wb_memtoreg[0]}),
             32'({1'b1, tab[i-2].d.rw, tab[i-2].d.m2r}));
    end

    // Load then ADD with MEM_LAT=4
    id_valid[1] = 1; id_opcode[1] = 4'h8;
    tick();
    id_opcode[1] = 4'h0;
    @(negedge clk); chkv("ld_add_ready", 32'(id_ready[1]), 32'd1);
    tick();
    id_valid[1] = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chkv($sformatf("ld_wait_%0d", c),
           32'({mem_busy[1], id_ready[1], wb_valid[1], ex_valid[1], mem_valid[1]}), 32'b10011);
      tick();
    end
    @(negedge clk);
    chkv("ld_wait_end", 32'({mem_busy[1], id_ready[1], mem_valid[1], mem_read[1]}), 32'b0111);
    tick();
    chkv("ld_in_wb", 32'({wb_valid[1], wb_regwrite[1], wb_memtoreg[1], mem_valid[1], mem_read[1]}), 32'b11110);
    tick();
    chkv("add_in_wb", 32'({wb_valid[1], wb_regwrite[1], wb_memtoreg[1]}), 32'b110);

    // One-cycle hazard stall after a load
    id_valid[0] = 1; id_opcode[0] = 4'h8;
    tick();
    id_opcode[0] = 4'h0; hz_stall[0] = 1;
    @(negedge clk); chkv("hz_ready", 32'(id_ready[0]), 32'd0);
    tick();
    chkv("hz_bubble", 32'({ex_valid[0], mem_valid[0], mem_read[0]}), 32'b011);
    hz_stall[0] = 0;
    @(negedge clk); chkv("hz_release_ready", 32'(id_ready[0]), 32'd1);
    tick();
    chkv("hz_add_in_ex", 32'({ex_valid[0], ex_aluop[0], ex_regdst[0], mem_valid[0], wb_valid[0], wb_memtoreg[0]}),
         32'b1_000_1_0_1_1);

    // Flushed halt is discarded
    id_opcode[0] = 4'hF; flush[0] = 1;
    @(negedge clk); chkv("flush_ready", 32'(id_ready[0]), 32'd1);
    tick();
    chkv("flush_bubble", 32'({ex_valid[0], halted[0]}), 32'b00);
    flush[0] = 0; id_opcode[0] = 4'h1;
    @(negedge clk); chkv("after_flush_ready", 32'(id_ready[0]), 32'd1);
    tick();
    chkv("after_flush_ex", 32'({ex_valid[0], ex_aluop[0]}), 32'b1_001);
    id_valid[0] = 0;

    // ADD, SW, HLT, ADD with MEM_LAT=2
    id_valid[2] = 1; id_opcode[2] = 4'h0;
    tick();
    id_opcode[2] = 4'h9;
    tick();
    id_opcode[2] = 4'hF;
    @(negedge clk); chkv("hlt_ready", 32'(id_ready[2]), 32'd1);
    tick();
    id_opcode[2] = 4'h0;
    hexp = '{4'b0011, 4'b0000, 4'b0010, 4'b0010, 4'b0100};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chkv($sformatf("drain_%0d", c), 32'({id_ready[2], halted[2], wb_valid[2], mem_busy[2]}), 32'(hexp[c]));
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chkv($sformatf("halted_%0d", c),
           32'({halted[2], id_ready[2], ex_valid[2], mem_valid[2], wb_valid[2]}), 32'b10000);
      tick();
    end
    rst_n[2] = 0;
    #1 chkv("halt_async_clear", 32'({halted[2], id_ready[2]}), 32'b01);
    tick();
    rst_n[2] = 1; id_valid[2] = 0;

    for (int k = 0; k < N; k++) run_random(k, 600);

`ifdef CTRL_PERF_EN
    rst_n[0] = 0;
    tick();
    rst_n[0] = 1;
    chkv("perf_reset", perf_retired[0] | perf_stall[0], 32'd0);
    issued = 0;
    for (int c = 0; c < 12; c++) begin
      id_valid[0] = 1;
      id_opcode[0] = 4'(issued);
      hz_stall[0] = (c == 3 || c == 7);
      tick();
      if (c != 3 && c != 7) issued++;
    end
    id_valid[0] = 0; hz_stall[0] = 0;
    repeat (3) tick();
    chkv("perf_retired", perf_retired[0], 32'd10);
    chkv("perf_stall", perf_stall[0], 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
